// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types, constants and nibble decode for the 7-segment scan driver
package seg7_pkg;

  // Index width covers the largest supported bank so every instance can share one type.
  localparam int DIGITS_MAX = 8;
  localparam int IDX_W      = (DIGITS_MAX > 1) ? $clog2(DIGITS_MAX) : 1;

  typedef logic [IDX_W-1:0] digit_idx_t;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Active-high lit patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_LIT_TABLE [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  function automatic logic [6:0] seg7_lit(input logic [3:0] nibble);
    return SEG_LIT_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - host data/control and display pin bundle for the scan driver
interface seg7_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] value_i;
  logic [DIGITS-1:0]   dp_i;
  logic                load_i;
  logic                blank_i;
  logic                lzs_en_i;
  logic [6:0]          seg_o;
  logic                dp_o;
  logic [DIGITS-1:0]   an_o;
  logic                frame_o;

  modport master (
    output value_i, dp_i, load_i, blank_i, lzs_en_i,
    input  seg_o, dp_o, an_o, frame_o
  );

  modport slave (
    input  value_i, dp_i, load_i, blank_i, lzs_en_i,
    output seg_o, dp_o, an_o, frame_o
  );
endinterface

// File: rtl/seg7_encode.sv
// rtl/seg7_encode.sv - nibble to segment encode with suppression and output polarity
module seg7_encode
  import seg7_pkg::*;
#(
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       suppress,
  output logic [6:0] seg,
  output logic       dp_seg
);

  logic [6:0] lit;

  always_comb begin
    lit    = suppress ? SEG_BLANK : seg7_lit(nibble);
    seg    = (SEG_ACTIVE_LOW != 0) ? ~lit : lit;
    dp_seg = (SEG_ACTIVE_LOW != 0) ? ~dp : dp;
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed 7-segment driver with frame-synchronous updates
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int GUARD          = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  seg7_scan_driver_if.slave  bus
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [6:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7f : 7'h00;
  localparam logic [DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [PW-1:0]       prescaler;
  digit_idx_t          index;
  logic [4*DIGITS-1:0] shadow, display;
  logic [DIGITS-1:0]   shadow_dp, display_dp;
  logic                pending;

  logic                tick, boundary, suppress, cur_dp, dp_next;
  logic [3:0]          nibble;
  logic [6:0]          seg_next;
  logic [DIGITS-1:0]   one_hot, an_next;

  assign tick     = (prescaler == PW'(REFRESH_DIV - 1));
  assign boundary = tick && (index == digit_idx_t'(DIGITS - 1));

  // Suppression clears as soon as any nibble at or above the current digit is non-zero.
  always_comb begin
    nibble   = 4'h0;
    cur_dp   = 1'b0;
    one_hot  = '0;
    suppress = bus.lzs_en_i && (index != '0);
    for (int k = 0; k < DIGITS; k++) begin
      if (index == digit_idx_t'(k)) begin
        nibble     = display[4*k +: 4];
        cur_dp     = display_dp[k];
        one_hot[k] = 1'b1;
      end
      if ((digit_idx_t'(k) >= index) && (display[4*k +: 4] != 4'h0)) begin
        suppress = 1'b0;
      end
    end
    if ((int'(prescaler) >= GUARD) && !bus.blank_i) begin
      an_next = (AN_ACTIVE_LOW != 0) ? ~one_hot : one_hot;
    end else begin
      an_next = AN_OFF;
    end
  end

  seg7_encode #(
    .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
  ) u_encode (
    .nibble  (nibble),
    .dp      (cur_dp),
    .suppress(suppress),
    .seg     (seg_next),
    .dp_seg  (dp_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler   <= '0;
      index       <= '0;
      shadow      <= '0;
      shadow_dp   <= '0;
      display     <= '0;
      display_dp  <= '0;
      pending     <= 1'b0;
      bus.seg_o   <= SEG_OFF;
      bus.dp_o    <= SEG_OFF[0];
      bus.an_o    <= AN_OFF;
      bus.frame_o <= 1'b0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick) begin
        index <= (index == digit_idx_t'(DIGITS - 1)) ? '0 : index + 1'b1;
      end

      // A load on the boundary bypasses the shadow so it lands in the frame that starts now.
      if (bus.load_i && boundary) begin
        display    <= bus.value_i;
        display_dp <= bus.dp_i;
        pending    <= 1'b0;
      end else if (bus.load_i) begin
        shadow    <= bus.value_i;
        shadow_dp <= bus.dp_i;
        pending   <= 1'b1;
      end else if (boundary && pending) begin
        display    <= shadow;
        display_dp <= shadow_dp;
        pending    <= 1'b0;
      end

      bus.seg_o   <= seg_next;
      bus.dp_o    <= dp_next;
      bus.an_o    <= an_next;
      bus.frame_o <= boundary;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg7_scan_driver_if #(.DIGITS(4)) bus ();

  seg7_scan_driver #(
    .DIGITS(4), .REFRESH_DIV(4), .GUARD(1), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [6:0] exp_seg [4];
  logic [3:0] exp_dp;
  logic [3:0] ea;
  int slot;

  localparam logic [6:0] S0 = 7'b1000000, S2 = 7'b0100100, S3 = 7'b0110000, S5 = 7'b0010010;
  localparam logic [6:0] S8 = 7'b0000000, SA = 7'b0001000, SF = 7'b0001110, SX = 7'b1111111;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.value_i = '0; bus.dp_i = '0; bus.load_i = 1'b0; bus.blank_i = 1'b0; bus.lzs_en_i = 1'b0;
    repeat (3) step();
    checks++; if (bus.an_o !== 4'b1111) begin errors++; $display("FAIL reset_an got %b want 1111", bus.an_o); end
    checks++; if (bus.seg_o !== SX) begin errors++; $display("FAIL reset_seg got %b want 1111111", bus.seg_o); end
    checks++; if (bus.dp_o !== 1'b1) begin errors++; $display("FAIL reset_dp got %b want 1", bus.dp_o); end
    checks++; if (bus.frame_o !== 1'b0) begin errors++; $display("FAIL reset_frame got %b want 0", bus.frame_o); end
    rst_n = 1'b1;
    exp_seg = '{S0, S0, S0, S0}; exp_dp = 4'b1111;
    for (int s = 0; s < 16; s++) begin
      step();
      slot = s / 4;
      ea = (s % 4 == 0) ? 4'hF : (4'hF ^ (4'b0001 << slot));
      checks++; if (bus.an_o !== ea) begin errors++; $display("FAIL scan_an t=%0d got %b want %b", s+1, bus.an_o, ea); end
      checks++; if (bus.seg_o !== exp_seg[slot]) begin errors++; $display("FAIL scan_seg t=%0d got %b want %b", s+1, bus.seg_o, exp_seg[slot]); end
      checks++; if (bus.frame_o !== (s == 15)) begin errors++; $display("FAIL scan_frame t=%0d got %b want %b", s+1, bus.frame_o, s == 15); end
    end
  endtask

  task automatic test_load();
    exp_seg = '{S0, S0, S0, S0}; exp_dp = 4'b1111;
    for (int s = 0; s < 16; s++) begin
      bus.load_i = 1'b0;
      if (s == 5) begin bus.load_i = 1'b1; bus.value_i = 16'h8A3F; bus.dp_i = 4'b0100; end
      step();
      slot = s / 4;
      ea = (s % 4 == 0) ? 4'hF : (4'hF ^ (4'b0001 << slot));
      checks++; if (bus.an_o !== ea) begin errors++; $display("FAIL hold_an t=%0d got %b want %b", s+1, bus.an_o, ea); end
      checks++; if (bus.seg_o !== exp_seg[slot]) begin errors++; $display("FAIL hold_seg t=%0d got %b want %b", s+1, bus.seg_o, exp_seg[slot]); end
    end
    checks++; if (bus.frame_o !== 1'b1) begin errors++; $display("FAIL hold_frame got %b want 1", bus.frame_o); end
  endtask

  task automatic test_multi_load();
    exp_seg = '{SF, S3, SA, S8}; exp_dp = 4'b1011;
    for (int s = 0; s < 16; s++) begin
      bus.load_i = 1'b0;
      if (s == 3) begin bus.load_i = 1'b1; bus.value_i = 16'h1111; bus.dp_i = 4'b0000; end
      if (s == 9) begin bus.load_i = 1'b1; bus.value_i = 16'h2222; bus.dp_i = 4'b0000; end
      step();
      slot = s / 4;
      ea = (s % 4 == 0) ? 4'hF : (4'hF ^ (4'b0001 << slot));
      checks++; if (bus.an_o !== ea) begin errors++; $display("FAIL new_an t=%0d got %b want %b", s+1, bus.an_o, ea); end
      checks++; if (bus.seg_o !== exp_seg[slot]) begin errors++; $display("FAIL new_seg t=%0d got %b want %b", s+1, bus.seg_o, exp_seg[slot]); end
      checks++; if (bus.dp_o !== exp_dp[slot]) begin errors++; $display("FAIL new_dp t=%0d got %b want %b", s+1, bus.dp_o, exp_dp[slot]); end
    end
    exp_seg = '{S2, S2, S2, S2}; exp_dp = 4'b1111;
    for (int s = 0; s < 16; s++) begin
      bus.load_i = 1'b0;
      if (s == 15) begin bus.load_i = 1'b1; bus.value_i = 16'h0050; bus.dp_i = 4'b0000; bus.lzs_en_i = 1'b1; end
      step();
      slot = s / 4;
      checks++; if (bus.seg_o !== exp_seg[slot]) begin errors++; $display("FAIL last_wins_seg t=%0d got %b want %b", s+1, bus.seg_o, exp_seg[slot]); end
      checks++; if (bus.dp_o !== exp_dp[slot]) begin errors++; $display("FAIL last_wins_dp t=%0d got %b want %b", s+1, bus.dp_o, exp_dp[slot]); end
    end
  endtask

  task automatic test_lzs();
    exp_seg = '{S0, S5, SX, SX}; exp_dp = 4'b1111;
    for (int s = 0; s < 16; s++) begin
      bus.load_i = 1'b0;
      if (s == 6) begin bus.load_i = 1'b1; bus.value_i = 16'h0000; bus.dp_i = 4'b0000; end
      step();
      slot = s / 4;
      ea = (s % 4 == 0) ? 4'hF : (4'hF ^ (4'b0001 << slot));
      checks++; if (bus.an_o !== ea) begin errors++; $display("FAIL lzs_an t=%0d got %b want %b", s+1, bus.an_o, ea); end
      checks++; if (bus.seg_o !== exp_seg[slot]) begin errors++; $display("FAIL lzs_seg t=%0d got %b want %b", s+1, bus.seg_o, exp_seg[slot]); end
    end
    exp_seg = '{S0, SX, SX, SX};
    for (int s = 0; s < 16; s++) begin
      bus.load_i = 1'b0;
      if (s == 6) begin bus.load_i = 1'b1; bus.value_i = 16'h8A3F; bus.dp_i = 4'b0100; end
      step();
      slot = s / 4;
      checks++; if (bus.seg_o !== exp_seg[slot]) begin errors++; $display("FAIL lzs_zero_seg t=%0d got %b want %b", s+1, bus.seg_o, exp_seg[slot]); end
    end
    bus.load_i = 1'b0;
  endtask

  task automatic test_blank();
    exp_seg = '{SF, S3, SA, S8}; exp_dp = 4'b1011;
    for (int s = 0; s < 16; s++) begin
      bus.blank_i = (s < 10);
      step();
      slot = s / 4;
      ea = ((s < 10) || (s % 4 == 0)) ? 4'hF : (4'hF ^ (4'b0001 << slot));
      checks++; if (bus.an_o !== ea) begin errors++; $display("FAIL blank_an t=%0d got %b want %b", s+1, bus.an_o, ea); end
      checks++; if (bus.seg_o !== exp_seg[slot]) begin errors++; $display("FAIL blank_seg t=%0d got %b want %b", s+1, bus.seg_o, exp_seg[slot]); end
      checks++; if (bus.dp_o !== exp_dp[slot]) begin errors++; $display("FAIL blank_dp t=%0d got %b want %b", s+1, bus.dp_o, exp_dp[slot]); end
    end
    checks++; if (bus.frame_o !== 1'b1) begin errors++; $display("FAIL blank_frame got %b want 1", bus.frame_o); end
  endtask

  task automatic test_reset_mid();
    for (int s = 0; s < 10; s++) step();
    checks++; if (bus.an_o !== 4'b1011) begin errors++; $display("FAIL mid_pre_an got %b want 1011", bus.an_o); end
    checks++; if (bus.seg_o !== SA) begin errors++; $display("FAIL mid_pre_seg got %b want %b", bus.seg_o, SA); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.an_o !== 4'b1111) begin errors++; $display("FAIL mid_rst_an got %b want 1111", bus.an_o); end
    checks++; if (bus.seg_o !== SX) begin errors++; $display("FAIL mid_rst_seg got %b want 1111111", bus.seg_o); end
    checks++; if (bus.dp_o !== 1'b1) begin errors++; $display("FAIL mid_rst_dp got %b want 1", bus.dp_o); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_seg = '{S0, SX, SX, SX}; exp_dp = 4'b1111;
    for (int s = 0; s < 16; s++) begin
      step();
      slot = s / 4;
      ea = (s % 4 == 0) ? 4'hF : (4'hF ^ (4'b0001 << slot));
      checks++; if (bus.an_o !== ea) begin errors++; $display("FAIL restart_an t=%0d got %b want %b", s+1, bus.an_o, ea); end
      checks++; if (bus.seg_o !== exp_seg[slot]) begin errors++; $display("FAIL restart_seg t=%0d got %b want %b", s+1, bus.seg_o, exp_seg[slot]); end
      checks++; if (bus.dp_o !== exp_dp[slot]) begin errors++; $display("FAIL restart_dp t=%0d got %b want %b", s+1, bus.dp_o, exp_dp[slot]); end
      checks++; if (bus.frame_o !== (s == 15)) begin errors++; $display("FAIL restart_frame t=%0d got %b want %b", s+1, bus.frame_o, s == 15); end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_multi_load();
    test_lzs();
    test_blank();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
